// File: rtl/nic_fifo_param_if.sv
// Processor register port and router local port of the parametrised NIC.
// slave is the NIC side, master is the processor/router side.
interface nic_fifo_param_if #(
  parameter int unsigned DATA_W = 64
) ();
  logic [1:0]        addr;
  logic [0:DATA_W-1] d_in;
  logic [0:DATA_W-1] d_out;
  logic              nicEn;
  logic              nicEnWr;
  logic              net_so;
  logic              net_ro;
  logic [0:DATA_W-1] net_do;
  logic              net_polarity;
  logic              net_si;
  logic              net_ri;
  logic [0:DATA_W-1] net_di;

  modport slave (
    input  addr, d_in, nicEn, nicEnWr, net_ro, net_polarity, net_si, net_di,
    output d_out, net_so, net_do, net_ri
  );

  modport master (
    output addr, d_in, nicEn, nicEnWr, net_ro, net_polarity, net_si, net_di,
    input  d_out, net_so, net_do, net_ri
  );
endinterface

// File: rtl/nic_fifo_param.sv
// Processor-to-ring NIC with independent output and input FIFOs.
// Bit 0 (leftmost) of a packet is the router polarity bit.
module nic_fifo_param #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned IN_DEPTH  = 4,
  parameter int unsigned CNT_W     = $clog2(((OUT_DEPTH > IN_DEPTH) ? OUT_DEPTH : IN_DEPTH) + 1)
) (
  input logic             clk,
  input logic             reset,
  nic_fifo_param_if.slave bus
);
  localparam int unsigned OPW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned IPW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [CNT_W-1:0] OUT_FULL_CNT = CNT_W'(OUT_DEPTH);
  localparam logic [CNT_W-1:0] IN_FULL_CNT  = CNT_W'(IN_DEPTH);
  localparam logic [OPW-1:0]   OUT_LAST     = OPW'(OUT_DEPTH - 1);
  localparam logic [IPW-1:0]   IN_LAST      = IPW'(IN_DEPTH - 1);

  typedef logic [0:DATA_W-1] data_t;

  data_t            out_mem_q [OUT_DEPTH];
  data_t            out_mem_d [OUT_DEPTH];
  data_t            in_mem_q  [IN_DEPTH];
  data_t            in_mem_d  [IN_DEPTH];
  logic [OPW-1:0]   out_wp_q, out_wp_d, out_rp_q, out_rp_d;
  logic [IPW-1:0]   in_wp_q, in_wp_d, in_rp_q, in_rp_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d, in_cnt_q, in_cnt_d;
  data_t            rd_data_q, rd_data_d;
  logic [1:0]       addr_q;
  logic             en_q;
  logic             ovf_q, ovf_d;

  logic             out_full, out_empty, in_full, in_empty;
  logic             out_wr, out_push, out_pop, out_drop;
  logic             in_rd, in_push, in_pop, ovf_clr;
  data_t            out_head, in_head;
  logic [CNT_W+1:0] out_stat;
  logic [CNT_W:0]   in_stat;

  always_comb begin
    out_full  = (out_cnt_q == OUT_FULL_CNT);
    out_empty = (out_cnt_q == '0);
    in_full   = (in_cnt_q == IN_FULL_CNT);
    in_empty  = (in_cnt_q == '0);
    out_head  = out_empty ? '0 : out_mem_q[out_rp_q];
    in_head   = in_mem_q[in_rp_q];

    out_wr    = bus.nicEn & bus.nicEnWr & (bus.addr == 2'b00);
    out_push  = out_wr & ~out_full;
    out_drop  = out_wr & out_full;
    out_pop   = bus.net_ro & ~out_empty & (bus.net_polarity != out_head[0]);
    in_push   = bus.net_si & ~in_full;
    in_rd     = bus.nicEn & ~bus.nicEnWr & (bus.addr == 2'b10);
    in_pop    = in_rd & ~in_empty;
    ovf_clr   = en_q & (addr_q == 2'b01) & ~bus.nicEnWr;

    out_stat  = {ovf_q, out_cnt_q, out_full};
    in_stat   = {in_cnt_q, ~in_empty};

    bus.net_do = out_head;
    bus.net_so = out_pop;
    bus.net_ri = ~in_full;
    bus.d_out  = '0;
    if (en_q) begin
      case (addr_q)
        2'b01:   bus.d_out = DATA_W'(out_stat);
        2'b10:   bus.d_out = rd_data_q;
        2'b11:   bus.d_out = DATA_W'(in_stat);
        default: bus.d_out = '0;
      endcase
    end
  end

  // Push/pop legality above is taken from pre-edge counts, so a pop never
  // frees room for a same-cycle push and a push never feeds a same-cycle pop.
  always_comb begin
    out_mem_d = out_mem_q;
    out_wp_d  = out_wp_q;
    out_rp_d  = out_rp_q;
    out_cnt_d = out_cnt_q;
    in_mem_d  = in_mem_q;
    in_wp_d   = in_wp_q;
    in_rp_d   = in_rp_q;
    in_cnt_d  = in_cnt_q;
    rd_data_d = rd_data_q;
    ovf_d     = out_drop | (ovf_q & ~ovf_clr);

    if (out_push) begin
      out_mem_d[out_wp_q] = bus.d_in;
      out_wp_d = (out_wp_q == OUT_LAST) ? '0 : out_wp_q + 1'b1;
    end
    if (out_pop) out_rp_d = (out_rp_q == OUT_LAST) ? '0 : out_rp_q + 1'b1;
    case ({out_push, out_pop})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase

    if (in_push) begin
      in_mem_d[in_wp_q] = bus.net_di;
      in_wp_d = (in_wp_q == IN_LAST) ? '0 : in_wp_q + 1'b1;
    end
    if (in_pop) in_rp_d = (in_rp_q == IN_LAST) ? '0 : in_rp_q + 1'b1;
    case ({in_push, in_pop})
      2'b10:   in_cnt_d = in_cnt_q + 1'b1;
      2'b01:   in_cnt_d = in_cnt_q - 1'b1;
      default: in_cnt_d = in_cnt_q;
    endcase

    if (in_rd) rd_data_d = in_empty ? '0 : in_head;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_mem_q <= '{default: '0};
      in_mem_q  <= '{default: '0};
      out_wp_q  <= '0;
      out_rp_q  <= '0;
      out_cnt_q <= '0;
      in_wp_q   <= '0;
      in_rp_q   <= '0;
      in_cnt_q  <= '0;
      rd_data_q <= '0;
      addr_q    <= '0;
      en_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      out_mem_q <= out_mem_d;
      in_mem_q  <= in_mem_d;
      out_wp_q  <= out_wp_d;
      out_rp_q  <= out_rp_d;
      out_cnt_q <= out_cnt_d;
      in_wp_q   <= in_wp_d;
      in_rp_q   <= in_rp_d;
      in_cnt_q  <= in_cnt_d;
      rd_data_q <= rd_data_d;
      addr_q    <= bus.addr;
      en_q      <= bus.nicEn;
      ovf_q     <= ovf_d;
    end
  end
endmodule

// File: tb/tb_nic_fifo_param.sv
// Bench for nic_fifo_param: directed vector table, hand-written corner
// sequences and random traffic, all checked against a queue-based model.
module tb_nic_fifo_param;
  localparam int unsigned DW = 64;
  localparam int unsigned OD = 4;
  localparam int unsigned ID = 4;
  localparam int unsigned CW = 3;

  typedef logic [0:DW-1] data_t;
  typedef struct {
    logic [1:0] addr;
    logic       en;
    logic       wr;
    data_t      din;
    logic       ro;
    logic       pol;
    logic       si;
    data_t      di;
    data_t      e_dout;
    logic       e_so;
    logic       e_ri;
    data_t      e_do;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  nic_fifo_param_if #(.DATA_W(DW)) bus ();

  nic_fifo_param #(
    .DATA_W(DW),
    .OUT_DEPTH(OD),
    .IN_DEPTH(ID)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_err = 0;

  // Reference model: FIFOs as queues, status words built arithmetically.
  data_t      mq_out[$];
  data_t      mq_in[$];
  logic       m_ovf;
  data_t      m_rd;
  logic [1:0] m_addr_q;
  logic       m_en_q;

  function automatic data_t m_do();
    return (mq_out.size() == 0) ? data_t'(0) : mq_out[0];
  endfunction

  function automatic logic m_so();
    data_t h = m_do();
    return bus.net_ro && (mq_out.size() != 0) && (bus.net_polarity != h[0]);
  endfunction

  function automatic logic m_ri();
    return mq_in.size() < ID;
  endfunction

  function automatic data_t m_dout();
    longint unsigned s;
    if (!m_en_q) return '0;
    case (m_addr_q)
      2'd1: begin
        s = (longint'(m_ovf) << (CW + 1)) + longint'(mq_out.size()) * 2
            + ((mq_out.size() == OD) ? 1 : 0);
        return data_t'(s);
      end
      2'd2: return m_rd;
      2'd3: begin
        s = longint'(mq_in.size()) * 2 + ((mq_in.size() != 0) ? 1 : 0);
        return data_t'(s);
      end
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    mq_out.delete();
    mq_in.delete();
    m_ovf = 1'b0;
    m_rd = '0;
    m_addr_q = 2'd0;
    m_en_q = 1'b0;
  endtask

  task automatic model_clock();
    logic  so, full_pre, wr_out, clr, rd_in, in_ok;
    so       = m_so();
    full_pre = (mq_out.size() == OD);
    wr_out   = bus.nicEn && bus.nicEnWr && (bus.addr == 2'd0);
    clr      = m_en_q && (m_addr_q == 2'd1) && !bus.nicEnWr;
    rd_in    = bus.nicEn && !bus.nicEnWr && (bus.addr == 2'd2);
    in_ok    = bus.net_si && (mq_in.size() < ID);
    if (so) void'(mq_out.pop_front());
    if (wr_out && !full_pre) mq_out.push_back(bus.d_in);
    if (rd_in) m_rd = (mq_in.size() != 0) ? mq_in.pop_front() : data_t'(0);
    if (in_ok) mq_in.push_back(bus.net_di);
    m_ovf = (wr_out && full_pre) || (m_ovf && !clr);
    m_addr_q = bus.addr;
    m_en_q = bus.nicEn;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t V(input logic [1:0] a, input logic en, input logic wr,
                             input data_t din, input logic ro, input logic pol,
                             input logic si, input data_t di, input data_t ed,
                             input logic eso, input logic eri, input data_t edo);
    vec_t v;
    v.addr = a;  v.en = en;  v.wr = wr;  v.din = din;
    v.ro = ro;   v.pol = pol; v.si = si; v.di = di;
    v.e_dout = ed; v.e_so = eso; v.e_ri = eri; v.e_do = edo;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.addr = v.addr;
    bus.nicEn = v.en;
    bus.nicEnWr = v.wr;
    bus.d_in = v.din;
    bus.net_ro = v.ro;
    bus.net_polarity = v.pol;
    bus.net_si = v.si;
    bus.net_di = v.di;
  endtask

  // Called #1 after a rising edge; drives, checks at the falling edge, clocks.
  task automatic run_vec(input vec_t v, input bit use_tbl, input string tag);
    drive(v);
    @(negedge clk);
    chk($sformatf("%s d_out", tag), bus.d_out, m_dout());
    chk($sformatf("%s net_so", tag), 64'(bus.net_so), 64'(m_so()));
    chk($sformatf("%s net_ri", tag), 64'(bus.net_ri), 64'(m_ri()));
    chk($sformatf("%s net_do", tag), bus.net_do, m_do());
    if (use_tbl) begin
      chk($sformatf("%s tbl d_out", tag), bus.d_out, v.e_dout);
      chk($sformatf("%s tbl net_so", tag), 64'(bus.net_so), 64'(v.e_so));
      chk($sformatf("%s tbl net_ri", tag), 64'(bus.net_ri), 64'(v.e_ri));
      chk($sformatf("%s tbl net_do", tag), bus.net_do, v.e_do);
    end
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk($sformatf("%s d_out", tag), bus.d_out, 64'd0);
    chk($sformatf("%s net_so", tag), 64'(bus.net_so), 64'd0);
    chk($sformatf("%s net_do", tag), bus.net_do, 64'd0);
    chk($sformatf("%s net_ri", tag), 64'(bus.net_ri), 64'd1);
  endtask

  localparam data_t P = 64'h8000_0000_0000_0001;

  initial begin
    vec_t tbl[$];
    vec_t v;

    drive(V(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("por");
    reset = 1'b1;

    //       addr en wr din   ro pol si di     d_out  so ri do
    tbl.push_back(V(1, 1, 0, 0,    0, 1, 0, 0,    0,     0, 1, 0));
    tbl.push_back(V(3, 1, 0, 0,    0, 1, 0, 0,    0,     0, 1, 0));
    tbl.push_back(V(0, 1, 1, 1,    0, 1, 0, 0,    0,     0, 1, 0));
    tbl.push_back(V(0, 1, 1, 2,    0, 1, 0, 0,    0,     0, 1, 1));
    tbl.push_back(V(0, 1, 1, 3,    0, 1, 0, 0,    0,     0, 1, 1));
    tbl.push_back(V(0, 1, 1, 4,    0, 1, 0, 0,    0,     0, 1, 1));
    tbl.push_back(V(1, 1, 0, 0,    0, 1, 0, 0,    0,     0, 1, 1));
    tbl.push_back(V(0, 1, 1, 'hAA, 0, 1, 0, 0,    9,     0, 1, 1));
    tbl.push_back(V(1, 1, 0, 0,    0, 1, 0, 0,    0,     0, 1, 1));
    tbl.push_back(V(0, 0, 0, 0,    1, 1, 0, 0,    'h19,  1, 1, 1));
    tbl.push_back(V(0, 0, 0, 0,    1, 1, 0, 0,    0,     1, 1, 2));
    tbl.push_back(V(0, 0, 0, 0,    1, 1, 0, 0,    0,     1, 1, 3));
    tbl.push_back(V(0, 0, 0, 0,    1, 1, 0, 0,    0,     1, 1, 4));
    tbl.push_back(V(1, 1, 0, 0,    1, 1, 0, 0,    0,     0, 1, 0));
    tbl.push_back(V(0, 1, 1, P,    1, 1, 0, 0,    0,     0, 1, 0));
    tbl.push_back(V(0, 0, 0, 0,    1, 1, 0, 0,    0,     0, 1, P));
    tbl.push_back(V(0, 0, 0, 0,    1, 1, 0, 0,    0,     0, 1, P));
    tbl.push_back(V(0, 0, 0, 0,    1, 0, 0, 0,    0,     1, 1, P));
    tbl.push_back(V(0, 0, 0, 0,    1, 0, 0, 0,    0,     0, 1, 0));
    tbl.push_back(V(0, 0, 0, 0,    0, 0, 1, 'h10, 0,     0, 1, 0));
    tbl.push_back(V(0, 0, 0, 0,    0, 0, 1, 'h11, 0,     0, 1, 0));
    tbl.push_back(V(0, 0, 0, 0,    0, 0, 1, 'h12, 0,     0, 1, 0));
    tbl.push_back(V(0, 0, 0, 0,    0, 0, 1, 'h13, 0,     0, 1, 0));
    tbl.push_back(V(3, 1, 0, 0,    0, 0, 0, 0,    0,     0, 0, 0));
    tbl.push_back(V(2, 1, 0, 0,    0, 0, 0, 0,    9,     0, 0, 0));
    tbl.push_back(V(2, 1, 0, 0,    0, 0, 0, 0,    'h10,  0, 1, 0));
    tbl.push_back(V(2, 1, 0, 0,    0, 0, 0, 0,    'h11,  0, 1, 0));
    tbl.push_back(V(2, 1, 0, 0,    0, 0, 0, 0,    'h12,  0, 1, 0));
    tbl.push_back(V(0, 0, 0, 0,    0, 0, 0, 0,    'h13,  0, 1, 0));
    tbl.push_back(V(2, 1, 0, 0,    0, 0, 0, 0,    0,     0, 1, 0));
    tbl.push_back(V(0, 0, 0, 0,    0, 0, 0, 0,    0,     0, 1, 0));

    foreach (tbl[i]) run_vec(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Input FIFO at count 2 with simultaneous push and pop.
    run_vec(V(0, 0, 0, 0, 0, 1, 1, 'h20, 0,    0, 1, 0), 1'b1, "pp0");
    run_vec(V(0, 0, 0, 0, 0, 1, 1, 'h21, 0,    0, 1, 0), 1'b1, "pp1");
    run_vec(V(2, 1, 0, 0, 0, 1, 1, 'h22, 0,    0, 1, 0), 1'b1, "pp2");
    run_vec(V(3, 1, 0, 0, 0, 1, 0, 0,    'h20, 0, 1, 0), 1'b1, "pp3");
    run_vec(V(2, 1, 0, 0, 0, 1, 0, 0,    5,    0, 1, 0), 1'b1, "pp4");
    run_vec(V(2, 1, 0, 0, 0, 1, 0, 0,    'h21, 0, 1, 0), 1'b1, "pp5");
    run_vec(V(0, 0, 0, 0, 0, 1, 0, 0,    'h22, 0, 1, 0), 1'b1, "pp6");

    // Full output FIFO: pop in the same cycle still rejects the push.
    run_vec(V(0, 1, 1, 'h31, 0, 1, 0, 0,    0,    0, 1, 0),    1'b1, "fp0");
    run_vec(V(0, 1, 1, 'h32, 0, 1, 0, 0,    0,    0, 1, 'h31), 1'b1, "fp1");
    run_vec(V(0, 1, 1, 'h33, 0, 1, 0, 0,    0,    0, 1, 'h31), 1'b1, "fp2");
    run_vec(V(0, 1, 1, 'h34, 0, 1, 0, 0,    0,    0, 1, 'h31), 1'b1, "fp3");
    run_vec(V(0, 1, 1, 'h55, 1, 1, 0, 0,    0,    1, 1, 'h31), 1'b1, "fp4");
    run_vec(V(1, 1, 0, 0,    0, 1, 0, 0,    0,    0, 1, 'h32), 1'b1, "fp5");
    run_vec(V(0, 0, 0, 0,    0, 1, 1, 'h77, 'h16, 0, 1, 'h32), 1'b1, "fp6");

    // Asynchronous reset mid-drain with three packets queued.
    drive(V(2, 1, 0, 0, 1, 1, 1, 'h99, 0, 0, 0, 0));
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    chk_reset_outs("rst_hold");
    reset = 1'b1;
    run_vec(V(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0), 1'b1, "rel0");
    run_vec(V(3, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0), 1'b1, "rel1");
    run_vec(V(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0), 1'b1, "rel2");

    for (int n = 0; n < 600; n++) begin
      v.addr = 2'($urandom_range(0, 3));
      v.en   = ($urandom_range(0, 3) != 0);
      v.wr   = 1'($urandom);
      v.din  = {$urandom, $urandom};
      v.ro   = ($urandom_range(0, 2) != 0);
      v.pol  = 1'($urandom);
      v.si   = 1'($urandom);
      v.di   = {$urandom, $urandom};
      v.e_dout = '0; v.e_so = 1'b0; v.e_ri = 1'b0; v.e_do = '0;
      run_vec(v, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
